// File: rtl/voxel_ram_arbiter.sv
// Single-port voxel RAM arbiter: loader writes win outright, traversal-unit reads
// are granted round-robin once the whole volume has been written, and read data
// is steered back to its requester by a fixed-latency tag pipeline.
module voxel_ram_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int RAM_LATENCY = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]        req_rvalid,
  input  logic                      load_valid,
  input  logic [ADDR_W-1:0]         load_addr,
  input  logic [DATA_W-1:0]         load_data,
  output logic                      init_done,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic                      ram_re,
  output logic                      ram_we,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = RAM_LATENCY + 1;
  localparam logic [ADDR_W:0] INIT_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0]             ram_addr_q, ram_addr_d;
  logic                          ram_re_q, ram_re_d;
  logic                          ram_we_q, ram_we_d;
  logic [DATA_W-1:0]             ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]             rdata_q, rdata_d;
  logic [NUM_REQ-1:0]            rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0]            pending_q, pending_d;
  logic [ID_W-1:0]               last_grant_q, last_grant_d;
  logic [ADDR_W:0]               cnt_q, cnt_d;
  logic                          init_q, init_d;
  logic [DEPTH-1:0]              tag_v_q;
  logic [DEPTH-1:0][ID_W-1:0]    tag_id_q;

  logic [NUM_REQ-1:0]            eligible;
  logic                          gnt_found;
  logic [ID_W-1:0]               gnt_id;
  logic                          do_read;
  logic                          ret_v;
  logic [ID_W-1:0]               ret_id;

  assign ret_v  = tag_v_q[DEPTH-1];
  assign ret_id = tag_id_q[DEPTH-1];

  // The return cycle itself is still part of the pending window, so the bit
  // being pulsed this cycle is masked even though pending has just cleared.
  assign eligible = req_valid & ~pending_q & ~rvalid_q;

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!gnt_found && eligible[(int'(last_grant_q) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    ram_addr_d   = ram_addr_q;
    ram_re_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_wdata_d  = ram_wdata_q;
    pending_d    = pending_q;
    last_grant_d = last_grant_q;
    do_read      = 1'b0;
    rvalid_d     = '0;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    init_d       = init_q | (cnt_q == INIT_FULL);

    if (ret_v) begin
      pending_d[ret_id] = 1'b0;
      rvalid_d          = NUM_REQ'(1) << ret_id;
      rdata_d           = ram_rdata;
    end

    if (load_valid) begin
      ram_we_d    = 1'b1;
      ram_addr_d  = load_addr;
      ram_wdata_d = load_data;
      if (cnt_q != INIT_FULL) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (init_q && gnt_found) begin
      do_read           = 1'b1;
      ram_re_d          = 1'b1;
      ram_addr_d        = req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
      pending_d[gnt_id] = 1'b1;
      last_grant_d      = gnt_id;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ram_addr_q   <= '0;
      ram_re_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      rdata_q      <= '0;
      rvalid_q     <= '0;
      pending_q    <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      init_q       <= 1'b0;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
    end else begin
      ram_addr_q   <= ram_addr_d;
      ram_re_q     <= ram_re_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      init_q       <= init_d;
      // Stage 0 lines up with ram_re; the last stage lines up with ram_rdata.
      tag_v_q      <= {tag_v_q[DEPTH-2:0], do_read};
      tag_id_q     <= {tag_id_q[DEPTH-2:0], gnt_id};
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_re     = ram_re_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
  assign req_rdata  = rdata_q;
  assign req_rvalid = rvalid_q;
  assign init_done  = init_q;

endmodule

// File: tb/tb_voxel_ram_arbiter.sv
// Bench for voxel_ram_arbiter: three instances (RAM latency 2, 1, 4) on a shared
// loader bus, each with its own behavioural RAM and requester stimulus.
module tb_voxel_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lv  = 1'b0;
  logic [3:0] la  = '0;
  logic [7:0] ld  = '0;

  logic [3:0]  rv     [3];
  logic [15:0] ra     [3];
  logic [7:0]  rdata  [3];
  logic [3:0]  rvalid [3];
  logic        init   [3];
  logic [3:0]  raddr  [3];
  logic        rre    [3];
  logic        rwe    [3];
  logic [7:0]  rwd    [3];
  logic [7:0]  rrd    [3];

  logic [7:0] shadow [16];
  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
    logic [7:0] mem  [16];
    logic [7:0] pipe [LAT];

    voxel_ram_arbiter #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(8), .RAM_LATENCY(LAT)) u_dut (
      .clk_in(clk), .rst_in(rst),
      .req_valid(rv[gi]), .req_addr(ra[gi]),
      .req_rdata(rdata[gi]), .req_rvalid(rvalid[gi]),
      .load_valid(lv), .load_addr(la), .load_data(ld),
      .init_done(init[gi]),
      .ram_addr(raddr[gi]), .ram_re(rre[gi]), .ram_we(rwe[gi]),
      .ram_wdata(rwd[gi]), .ram_rdata(rrd[gi])
    );

    always_ff @(posedge clk) begin
      if (rwe[gi]) mem[raddr[gi]] <= rwd[gi];
      pipe[0] <= mem[raddr[gi]];
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
    assign rrd[gi] = pipe[LAT-1];
  end

  typedef struct {
    logic       lv;
    logic [3:0] la;
    logic [7:0] ld;
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic       init;
    logic [3:0] rvl;
    logic [7:0] rd;
  } vec_t;
  vec_t tbl [32];

  task automatic set_row(int n, logic lv_, logic [3:0] la_, logic [7:0] ld_, logic we_,
                         logic re_, logic [3:0] addr_, logic init_, logic [3:0] rv_, logic [7:0] rd_);
    tbl[n] = '{lv: lv_, la: la_, ld: ld_, we: we_, re: re_, addr: addr_, init: init_, rvl: rv_, rd: rd_};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lv  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  function automatic logic [63:0] out_vec(int k);
    return {35'd0, rvalid[k], rdata[k], rre[k], rwe[k], raddr[k], rwd[k], init[k]};
  endfunction

  initial begin
    int ci, cr, cp, lre, lpl, npulse, nre, bad;
    logic [7:0] pdata;
    logic [3:0] pval;
    int waiting [3][4];
    int age     [3][4];
    logic [3:0] wa [3][4];
    int maxage  [3];
    int nsb     [3];

    for (int n = 0; n < 16; n++)
      set_row(n, 1'b1, 4'(n), 8'(7*n + 1), (n > 0), 1'b0, (n > 0) ? 4'(n-1) : 4'd0, 1'b0, 4'b0, 8'd0);
    set_row(16, 0, 0, 0,     1, 0, 15, 0, 4'b0000, 0);
    set_row(17, 0, 0, 0,     0, 0, 15, 1, 4'b0000, 0);
    set_row(18, 0, 0, 0,     0, 1,  5, 1, 4'b0000, 0);
    set_row(19, 0, 0, 0,     0, 1,  9, 1, 4'b0000, 0);
    set_row(20, 0, 0, 0,     0, 1, 12, 1, 4'b0000, 0);
    set_row(21, 0, 0, 0,     0, 1,  3, 1, 4'b0001, 36);
    set_row(22, 0, 0, 0,     0, 0,  3, 1, 4'b0010, 64);
    set_row(23, 1, 0, 8'hEE, 0, 1,  5, 1, 4'b0100, 85);
    set_row(24, 1, 0, 8'hEF, 1, 0,  0, 1, 4'b1000, 22);
    set_row(25, 1, 0, 8'hF0, 1, 0,  0, 1, 4'b0000, 22);
    set_row(26, 0, 0, 0,     1, 0,  0, 1, 4'b0001, 36);
    set_row(27, 0, 0, 0,     0, 1,  9, 1, 4'b0000, 36);
    set_row(28, 0, 0, 0,     0, 1, 12, 1, 4'b0000, 36);
    set_row(29, 0, 0, 0,     0, 1,  3, 1, 4'b0000, 36);
    set_row(30, 0, 0, 0,     0, 1,  5, 1, 4'b0010, 64);
    set_row(31, 0, 0, 0,     0, 0,  5, 1, 4'b0100, 85);

    for (int k = 0; k < 3; k++) begin
      rv[k] = '0;
      ra[k] = '0;
    end

    // Reset state on every instance.
    do_reset();
    for (int k = 0; k < 3; k++) chk($sformatf("reset_state_%0d", k), out_vec(k), 64'd0);

    // Init gating with requester 0 asking from reset; data = addr.
    rv[0] = 4'b0001;
    ra[0] = {4'd3, 4'd12, 4'd9, 4'd5};
    ci = -1; cr = -1; cp = -1; bad = 0; pdata = '0; pval = '0;
    for (int n = 0; n < 60 && cp < 0; n++) begin
      if (init[0] && ci < 0) ci = n;
      if (rre[0] && cr < 0) cr = n;
      if (rre[0] && !init[0]) bad = 1;
      if (rvalid[0] != 4'b0 && cp < 0) begin
        cp = n; pdata = rdata[0]; pval = rvalid[0]; rv[0] = 4'b0;
      end
      lv = (n < 16);
      la = 4'(n);
      ld = 8'(n);
      if (n < 16) shadow[n] = 8'(n);
      tick();
    end
    lv = 1'b0;
    chk("init_no_re_before_done", 64'(bad), 64'd0);
    chk("init_done_cycle", 64'(ci), 64'd17);
    chk("init_first_re_cycle", 64'(cr), 64'd18);
    chk("init_rvalid_cycle", 64'(cp), 64'd21);
    chk("init_rvalid_id", 64'(pval), 64'b0001);
    chk("init_rdata", 64'(pdata), 64'd5);
    $display("[TB] init gating: done@%0d re@%0d rvalid@%0d data=%0d", ci, cr, cp, pdata);
    for (int n = 0; n < 8; n++) tick();

    // Hold-off: requester 2 keeps req_valid high across its pulses.
    rv[0] = 4'b0100;
    lre = -1; lpl = -1; npulse = 0; nre = 0;
    for (int n = 0; n < 38; n++) begin
      if (rre[0]) begin
        if (lre >= 0) chk("holdoff_grant_gap", 64'(n - lre), 64'd5);
        if (lpl >= 0) chk("holdoff_pulse_to_re", 64'(n - lpl), 64'd2);
        lre = n;
        nre++;
      end
      if (rvalid[0] != 4'b0) begin
        chk("holdoff_pulse_id", 64'(rvalid[0]), 64'b0100);
        chk("holdoff_pulse_data", 64'(rdata[0]), 64'd12);
        lpl = n;
        npulse++;
      end
      if (n == 30) rv[0] = 4'b0;
      tick();
    end
    chk("holdoff_one_pulse_per_grant", 64'(npulse), 64'(nre));
    $display("[TB] hold-off: %0d grants, %0d pulses", nre, npulse);

    // Reset one cycle after two grants are in flight.
    rv[0] = 4'b1111;
    nre = 0;
    for (int n = 0; n < 20 && nre < 2; n++) begin
      if (rre[0]) nre++;
      if (nre < 2) tick();
    end
    chk("midflight_two_grants", 64'(nre), 64'd2);
    tick();
    rst = 1'b1;
    tick();
    chk("midflight_reset_outputs", out_vec(0), 64'd0);
    tick();
    rst = 1'b0;
    cyc = 0;

    // Re-init with all four requesting: gating, round-robin, write priority.
    for (int r = 0; r < 32; r++) begin
      lv = tbl[r].lv;
      la = tbl[r].la;
      ld = tbl[r].ld;
      if (tbl[r].lv) shadow[tbl[r].la] = tbl[r].ld;
      chk($sformatf("table_row_%0d", r),
          64'({rwe[0], rre[0], raddr[0], init[0], rvalid[0], rdata[0]}),
          64'({tbl[r].we, tbl[r].re, tbl[r].addr, tbl[r].init, tbl[r].rvl, tbl[r].rd}));
      $display("[TB] row %0d: we=%0b re=%0b addr=%0d init=%0b rvalid=%b rdata=%0d",
               r, rwe[0], rre[0], raddr[0], init[0], rvalid[0], rdata[0]);
      tick();
    end
    lv = 1'b0;
    rv[0] = 4'b0;
    for (int n = 0; n < 10; n++) tick();

    // Latency sweep with random request timing and stall writes.
    for (int k = 0; k < 3; k++) begin
      maxage[k] = 0;
      nsb[k] = 0;
      for (int i = 0; i < 4; i++) begin
        waiting[k][i] = 0;
        age[k][i] = 0;
        wa[k][i] = '0;
      end
    end
    for (int c = 0; c < 700; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (rvalid[k] != 4'b0) chk($sformatf("sb_onehot_%0d", k), 64'($onehot(rvalid[k])), 64'd1);
        for (int i = 0; i < 4; i++) begin
          if (rvalid[k][i]) begin
            chk($sformatf("sb_owner_%0d_%0d", k, i), 64'(waiting[k][i]), 64'd1);
            chk($sformatf("sb_data_%0d_%0d", k, i), 64'(rdata[k]), 64'(shadow[wa[k][i]]));
            waiting[k][i] = 0;
            rv[k][i] = 1'b0;
            nsb[k]++;
          end else if (waiting[k][i] != 0) begin
            age[k][i]++;
            if (age[k][i] > maxage[k]) maxage[k] = age[k][i];
          end else if (c < 640 && $urandom_range(0, 2) == 0) begin
            wa[k][i] = 4'($urandom_range(0, 15));
            ra[k][i*4 +: 4] = wa[k][i];
            rv[k][i] = 1'b1;
            waiting[k][i] = 1;
            age[k][i] = 0;
          end
        end
      end
      lv = (c < 640) && ($urandom_range(0, 5) == 0);
      la = 4'($urandom_range(0, 15));
      ld = shadow[la];
      tick();
    end
    lv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bad = 0;
      for (int i = 0; i < 4; i++) bad += waiting[k][i];
      chk($sformatf("sb_all_served_%0d", k), 64'(bad), 64'd0);
      chk($sformatf("sb_latency_bound_%0d", k), 64'(maxage[k] <= 40), 64'd1);
      chk($sformatf("sb_activity_%0d", k), 64'(nsb[k] > 50), 64'd1);
      $display("[TB] sweep inst %0d: %0d reads returned, max wait %0d", k, nsb[k], maxage[k]);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
